// File: rtl/riscv_mc_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes, FSM states
// and datapath mux selects.
package riscv_mc_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADR   = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10,
        S_JALR_PC   = 4'd11,
        S_LINK_WB   = 4'd12,
        S_LUI_WB    = 4'd13
    } state_t;

endpackage

// File: rtl/riscv_multicycle_controller_if.sv
// Controller <-> datapath signal bundle; state is exposed for observation only.
interface riscv_multicycle_controller_if;
    import riscv_mc_pkg::*;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       zero;
    logic       alu_lt;
    logic       mem_ready;

    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [2:0] ImmSrc;
    logic       RegWrite;
    logic       instr_done;
    logic       illegal;
    state_t     state;

    modport master (
        input  opcode, funct3, zero, alu_lt, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUOp, ImmSrc, RegWrite, instr_done, illegal, state
    );

    modport slave (
        output opcode, funct3, zero, alu_lt, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUOp, ImmSrc, RegWrite, instr_done, illegal, state
    );

endinterface

// File: rtl/riscv_multicycle_controller_branch_cond.sv
// Branch outcome from ALU flags; shared with the pipelined core.
module branch_cond
    import riscv_mc_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       alu_lt,
    output logic       taken,
    output logic       bad_funct3
);

    always_comb begin
        taken      = 1'b0;
        bad_funct3 = 1'b0;
        case (funct3)
            F3_BEQ:  taken = zero;
            F3_BNE:  taken = ~zero;
            F3_BLT:  taken = alu_lt;
            F3_BGE:  taken = ~alu_lt;
            default: bad_funct3 = 1'b1;
        endcase
    end

endmodule

// File: rtl/riscv_multicycle_controller.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/memory/writeback with
// memory wait handshake; outputs are decoded from state.
module riscv_multicycle_controller
    import riscv_mc_pkg::*;
#(
    parameter int MEM_WAIT = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    riscv_multicycle_controller_if.master  bus
);

    state_t state, state_nxt;
    logic   rdy;
    logic   taken;
    logic   bad_f3;

    assign rdy       = (MEM_WAIT != 0) ? bus.mem_ready : 1'b1;
    assign bus.state = state;

    branch_cond u_branch_cond (
        .funct3     (bus.funct3),
        .zero       (bus.zero),
        .alu_lt     (bus.alu_lt),
        .taken      (taken),
        .bad_funct3 (bad_f3)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt      = S_FETCH;
        bus.PCWrite    = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.ResultSrc  = RES_ALUOUT;
        bus.ALUSrcA    = SRCA_PC;
        bus.ALUSrcB    = SRCB_B;
        bus.ALUOp      = ALUOP_ADD;
        bus.ImmSrc     = IMM_I;
        bus.RegWrite   = 1'b0;
        bus.instr_done = 1'b0;
        bus.illegal    = 1'b0;

        case (state)
            S_FETCH: begin
                bus.ALUSrcB   = SRCB_FOUR;
                bus.ResultSrc = RES_ALURES;
                bus.IRWrite   = rdy;
                bus.PCWrite   = rdy;
                state_nxt     = rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                bus.ALUSrcA = SRCA_OLDPC;
                bus.ALUSrcB = SRCB_IMM;
                if (bus.opcode == OP_JAL)         bus.ImmSrc = IMM_J;
                else if (bus.opcode == OP_BRANCH) bus.ImmSrc = IMM_B;
                case (bus.opcode)
                    OP_LOAD, OP_STORE: state_nxt = S_MEM_ADR;
                    OP_OP:             state_nxt = S_EXEC_R;
                    OP_OPIMM:          state_nxt = S_EXEC_I;
                    OP_BRANCH:         state_nxt = S_BRANCH;
                    OP_JAL:            state_nxt = S_JAL;
                    OP_JALR:           state_nxt = S_JALR_PC;
                    OP_LUI:            state_nxt = S_LUI_WB;
                    default: begin
                        bus.illegal    = 1'b1;
                        bus.instr_done = 1'b1;
                        state_nxt      = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADR: begin
                bus.ALUSrcA = SRCA_A;
                bus.ALUSrcB = SRCB_IMM;
                bus.ImmSrc  = (bus.opcode == OP_STORE) ? IMM_S : IMM_I;
                state_nxt   = (bus.opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                bus.AdrSrc = 1'b1;
                state_nxt  = rdy ? S_MEM_WB : S_MEM_READ;
            end
            S_MEM_WB: begin
                bus.ResultSrc  = RES_DATA;
                bus.RegWrite   = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                bus.AdrSrc     = 1'b1;
                bus.MemWrite   = 1'b1;
                bus.instr_done = rdy;
                state_nxt      = rdy ? S_FETCH : S_MEM_WRITE;
            end
            S_EXEC_R: begin
                bus.ALUSrcA = SRCA_A;
                bus.ALUOp   = ALUOP_FUNC;
                state_nxt   = S_ALU_WB;
            end
            S_EXEC_I: begin
                bus.ALUSrcA = SRCA_A;
                bus.ALUSrcB = SRCB_IMM;
                bus.ALUOp   = ALUOP_FUNC;
                state_nxt   = S_ALU_WB;
            end
            S_ALU_WB: begin
                bus.RegWrite   = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_BRANCH: begin
                bus.ALUSrcA    = SRCA_A;
                bus.ALUOp      = ALUOP_SUB;
                bus.PCWrite    = taken;
                bus.illegal    = bad_f3;
                bus.instr_done = 1'b1;
            end
            S_JAL: begin
                bus.PCWrite = 1'b1;
                state_nxt   = S_LINK_WB;
            end
            S_JALR_PC: begin
                bus.ALUSrcA   = SRCA_A;
                bus.ALUSrcB   = SRCB_IMM;
                bus.ResultSrc = RES_ALURES;
                bus.PCWrite   = 1'b1;
                state_nxt     = S_LINK_WB;
            end
            S_LINK_WB: begin
                // rd <= OldPC + 4, the return address
                bus.ALUSrcA    = SRCA_OLDPC;
                bus.ALUSrcB    = SRCB_FOUR;
                bus.ResultSrc  = RES_ALURES;
                bus.RegWrite   = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_LUI_WB: begin
                bus.ImmSrc     = IMM_U;
                bus.ResultSrc  = RES_IMM;
                bus.RegWrite   = 1'b1;
                bus.instr_done = 1'b1;
            end
            default: state_nxt = S_FETCH;
        endcase

        // Reset silences every strobe and select, even mid-instruction.
        if (!rst_n) begin
            bus.PCWrite    = 1'b0;
            bus.AdrSrc     = 1'b0;
            bus.MemWrite   = 1'b0;
            bus.IRWrite    = 1'b0;
            bus.ResultSrc  = 2'b00;
            bus.ALUSrcA    = 2'b00;
            bus.ALUSrcB    = 2'b00;
            bus.ALUOp      = 2'b00;
            bus.ImmSrc     = 3'b000;
            bus.RegWrite   = 1'b0;
            bus.instr_done = 1'b0;
            bus.illegal    = 1'b0;
        end
    end

endmodule
